pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter and sequences next-PC selection for the single-issue RISC-V core.
- Chooses between the sequential PC+4 and the branch/jump target resolved in execute, and emits the 1-bit PC-source select.
- Generates the decode/execute flush strobes for taken redirects.
- Holds a redirect in a pending buffer until instruction fetch accepts it, and honours hazard-unit stalls.

Parameters:
- DATA_WIDTH, 32, width of PC and target.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0010, redirect destination for misaligned targets; used only with the optional feature.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redir_valid  in  1  taken branch/jump resolved in execute this cycle.
- redir_target  in  DATA_WIDTH  branch/jump target address.
- stall  in  1  hazard-unit stall (load-use); freezes PC.
- imem_ready  in  1  fetch accepts the current PC; PC may advance.
- pc  out  DATA_WIDTH  current fetch PC (registered).
- pc_next  out  DATA_WIDTH  combinational next-PC value.
- pc_src  out  1  0 = PC+4 selected, 1 = target selected.
- flush_d  out  1  squash instruction in decode.
- flush_e  out  1  squash instruction entering execute.
- redir_pending  out  1  redirect buffered, waiting for fetch.

Behaviour:
- Clock, reset, and base behaviour
  - One clock domain.
  - Reset is asynchronous assert, synchronous-to-clk deassert release, active-low.
  - Reset values: pc = RESET_PC; state RUN; pend_target = 0; pc_src = 0; flush_d = 0; flush_e = 0; redir_pending = 0.
  - pc_next = pc + 4 in RUN with no redirect. Addition wraps modulo 2^DATA_WIDTH; 32'hFFFF_FFFC + 4 = 0.
  - Target alignment: redir_target[1:0] is forced to 00 before use (without the optional feature).
- States: RUN, PEND.
- RUN
  - If redir_valid and imem_ready:
    - pc_src = 1, pc_next = target, flush_d = 1, flush_e = 1 (combinational, same cycle).
    - pc <= target at the next edge; remain in RUN.
  - If redir_valid and !imem_ready:
    - pc_src = 1, flush_d = 1, flush_e = 1 this cycle.
    - pend_target <= target; go to PEND.
  - Else if stall or !imem_ready: pc holds; pc_src = 0.
  - Else: pc <= pc + 4.
  - Priority: redir_valid over stall. A redirect during stall still proceeds; stall is ignored that cycle.
- PEND
  - redir_pending = 1, pc_src = 1, pc_next = pend_target, flush_d = 1 every cycle. flush_e = 0 unless a new redir_valid arrives.
  - stall is ignored.
  - New redir_valid in PEND:
    - pend_target is overwritten (last wins); flush_e = 1 that cycle.
    - If imem_ready in the same cycle, pc <= new target directly.
  - When imem_ready: pc <= pend_target (or the new target per above); go to RUN. redir_pending falls the cycle after.
- Latency
  - Redirect with fetch ready: 1 cycle from redir_valid to pc = target.
  - Otherwise: 1 cycle after the first imem_ready.
- Reset asserted mid-PEND: pending target discarded; pc = RESET_PC immediately (async).

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Extra output misaligned  out  1.
  - A redirect with redir_target[1:0] != 0 pulses misaligned for 1 cycle (same cycle as redir_valid).
  - The redirect goes to TRAP_VECTOR instead of the target; all other sequencing is unchanged, including PEND buffering of TRAP_VECTOR.
- Undefined: no misaligned port; low two bits are cleared and execution continues at the aligned target.

Test Plan:
- Reset release, imem_ready = 1, no stall, 4 cycles -> pc = 0, 4, 8, 12; pc_src = 0; flushes low.
- pc = 8, redir_valid = 1, redir_target = 32'h100, imem_ready = 1 -> same cycle pc_src = 1, flush_d = 1, flush_e = 1; next cycle pc = 32'h100, then 32'h104.
- redir_valid with target 32'h200 while imem_ready = 0 for 3 cycles:
  - redir_pending = 1 and flush_d = 1 for 3 cycles; pc unchanged.
  - First imem_ready = 1 cycle -> next pc = 32'h200.
- stall = 1 for 2 cycles at pc = 32'h40 -> pc stays 32'h40.
- stall = 1 together with redir_valid, target 32'h80 -> pc = 32'h80 next cycle (redirect wins).
- In PEND with pend_target 32'h300:
  - Second redir_valid with target 32'h400 -> pc = 32'h400 after imem_ready.
  - rst_n low mid-PEND -> pc = 0 immediately, redir_pending = 0.
  - With PC_MISALIGN_TRAP_EN, target 32'h102 -> misaligned pulse, pc = 32'h10.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and next-PC sequencer
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = DATA_WIDTH'(32'h0000_0010)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redir_valid,
  input  logic [DATA_WIDTH-1:0] redir_target,
  input  logic                  stall,
  input  logic                  imem_ready,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_next,
  output logic                  pc_src,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  redir_pending
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic                  misaligned
`endif
);

  typedef enum logic {RUN, PEND} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pend_target_q, pend_target_d;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] eff_target;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  trap_hit;

`ifdef PC_MISALIGN_TRAP_EN
  assign trap_hit   = redir_valid && (redir_target[1:0] != 2'b00);
  assign misaligned = trap_hit;
`else
  assign trap_hit   = 1'b0;
`endif

  // Without the trap a misaligned target is silently rounded down to a word.
  assign eff_target = trap_hit ? TRAP_VECTOR
                               : (redir_target & ~DATA_WIDTH'(3));
  assign pc_plus4   = pc_q + DATA_WIDTH'(4);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    next_pc       = pc_plus4;
    pc_src        = 1'b0;
    flush_d       = 1'b0;
    flush_e       = 1'b0;
    case (state_q)
      RUN: begin
        if (redir_valid) begin
          pc_src  = 1'b1;
          flush_d = 1'b1;
          flush_e = 1'b1;
          next_pc = eff_target;
          if (imem_ready) begin
            pc_d = eff_target;
          end else begin
            pend_target_d = eff_target;
            state_d       = PEND;
          end
        end else if (!stall && imem_ready) begin
          pc_d = pc_plus4;
        end
      end
      PEND: begin
        // Stall is deliberately ignored: the redirect must land before anything else.
        pc_src  = 1'b1;
        flush_d = 1'b1;
        next_pc = pend_target_q;
        if (redir_valid) begin
          flush_e       = 1'b1;
          pend_target_d = eff_target;
          next_pc       = eff_target;
        end
        if (imem_ready) begin
          pc_d    = next_pc;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc            = pc_q;
  assign pc_next       = next_pc;
  assign redir_pending = (state_q == PEND);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        stall;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_src;
  logic        flush_d;
  logic        flush_e;
  logic        redir_pending;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int checks;
  int fails;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .stall        (stall),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .pc_next      (pc_next),
    .pc_src       (pc_src),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .redir_pending(redir_pending)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misaligned   (misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {pc_src, flush_d, flush_e, redir_pending}
  wire [3:0] ctl = {pc_src, flush_d, flush_e, redir_pending};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    redir_valid = 1'b0;
    redir_target = '0;
    stall = 1'b0;
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc actual=%h expected=%h", pc, 32'h0); end
    checks++;
    if (ctl !== 4'b0000) begin fails++; $display("FAIL reset_ctl actual=%b expected=%b", ctl, 4'b0000); end
    checks++;
    if (pc_next !== 32'h4) begin fails++; $display("FAIL reset_pc_next actual=%h expected=%h", pc_next, 32'h4); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (pc !== 32'(i * 4)) begin fails++; $display("FAIL seq_pc[%0d] actual=%h expected=%h", i, pc, 32'(i * 4)); end
      checks++;
      if (ctl !== 4'b0000) begin fails++; $display("FAIL seq_ctl[%0d] actual=%b expected=%b", i, ctl, 4'b0000); end
      tick();
    end
  endtask

  task automatic test_redirect();
    redir_valid = 1'b1;
    redir_target = 32'h100;
    #1;
    checks++;
    if (ctl !== 4'b1110) begin fails++; $display("FAIL redir_ctl actual=%b expected=%b", ctl, 4'b1110); end
    checks++;
    if (pc_next !== 32'h100) begin fails++; $display("FAIL redir_pc_next actual=%h expected=%h", pc_next, 32'h100); end
    tick();
    redir_valid = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h100) begin fails++; $display("FAIL redir_pc actual=%h expected=%h", pc, 32'h100); end
    checks++;
    if (ctl !== 4'b0000) begin fails++; $display("FAIL redir_after_ctl actual=%b expected=%b", ctl, 4'b0000); end
    tick();
    #1;
    checks++;
    if (pc !== 32'h104) begin fails++; $display("FAIL redir_pc_plus4 actual=%h expected=%h", pc, 32'h104); end
  endtask

  task automatic test_pend();
    imem_ready = 1'b0;
    redir_valid = 1'b1;
    redir_target = 32'h200;
    #1;
    checks++;
    if (ctl !== 4'b1110) begin fails++; $display("FAIL pend_entry_ctl actual=%b expected=%b", ctl, 4'b1110); end
    tick();
    redir_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== 4'b1101) begin fails++; $display("FAIL pend_ctl[%0d] actual=%b expected=%b", i, ctl, 4'b1101); end
      checks++;
      if (pc !== 32'h104) begin fails++; $display("FAIL pend_pc_hold[%0d] actual=%h expected=%h", i, pc, 32'h104); end
      checks++;
      if (pc_next !== 32'h200) begin fails++; $display("FAIL pend_pc_next[%0d] actual=%h expected=%h", i, pc_next, 32'h200); end
      tick();
    end
    imem_ready = 1'b1;
    #1;
    checks++;
    if (redir_pending !== 1'b1) begin fails++; $display("FAIL pend_ready_pending actual=%b expected=%b", redir_pending, 1'b1); end
    tick();
    #1;
    checks++;
    if (pc !== 32'h200) begin fails++; $display("FAIL pend_release_pc actual=%h expected=%h", pc, 32'h200); end
    checks++;
    if (ctl !== 4'b0000) begin fails++; $display("FAIL pend_release_ctl actual=%b expected=%b", ctl, 4'b0000); end
  endtask

  task automatic test_stall();
    redir_valid = 1'b1;
    redir_target = 32'h40;
    tick();
    redir_valid = 1'b0;
    stall = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h40 || pc_src !== 1'b0) begin fails++; $display("FAIL stall_start pc=%h pc_src=%b expected pc=%h pc_src=0", pc, pc_src, 32'h40); end
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      checks++;
      if (pc !== 32'h40) begin fails++; $display("FAIL stall_hold[%0d] actual=%h expected=%h", i, pc, 32'h40); end
    end
    stall = 1'b0;
    tick();
    #1;
    checks++;
    if (pc !== 32'h44) begin fails++; $display("FAIL stall_resume actual=%h expected=%h", pc, 32'h44); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1;
    redir_valid = 1'b1;
    redir_target = 32'h80;
    #1;
    checks++;
    if (ctl !== 4'b1110) begin fails++; $display("FAIL stall_redir_ctl actual=%b expected=%b", ctl, 4'b1110); end
    tick();
    redir_valid = 1'b0;
    stall = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h80) begin fails++; $display("FAIL stall_redir_pc actual=%h expected=%h", pc, 32'h80); end
    tick();
    #1;
    checks++;
    if (pc !== 32'h84) begin fails++; $display("FAIL stall_redir_next actual=%h expected=%h", pc, 32'h84); end
  endtask

  task automatic test_pend_overwrite();
    imem_ready = 1'b0;
    redir_valid = 1'b1;
    redir_target = 32'h300;
    tick();
    redir_target = 32'h400;
    #1;
    checks++;
    if (ctl !== 4'b1111) begin fails++; $display("FAIL overwrite_ctl actual=%b expected=%b", ctl, 4'b1111); end
    checks++;
    if (pc_next !== 32'h400) begin fails++; $display("FAIL overwrite_pc_next actual=%h expected=%h", pc_next, 32'h400); end
    tick();
    redir_valid = 1'b0;
    #1;
    checks++;
    if (pc_next !== 32'h400 || pc !== 32'h84) begin fails++; $display("FAIL overwrite_held pc_next=%h pc=%h expected pc_next=%h pc=%h", pc_next, pc, 32'h400, 32'h84); end
    checks++;
    if (ctl !== 4'b1101) begin fails++; $display("FAIL overwrite_held_ctl actual=%b expected=%b", ctl, 4'b1101); end
    stall = 1'b1;
    imem_ready = 1'b1;
    tick();
    stall = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h400 || redir_pending !== 1'b0) begin fails++; $display("FAIL overwrite_release pc=%h pending=%b expected pc=%h pending=0", pc, redir_pending, 32'h400); end
  endtask

  task automatic test_pend_redirect_ready();
    imem_ready = 1'b0;
    redir_valid = 1'b1;
    redir_target = 32'h500;
    tick();
    redir_target = 32'h600;
    imem_ready = 1'b1;
    tick();
    redir_valid = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h600 || redir_pending !== 1'b0) begin fails++; $display("FAIL pend_direct pc=%h pending=%b expected pc=%h pending=0", pc, redir_pending, 32'h600); end
  endtask

  task automatic test_reset_mid_pend();
    imem_ready = 1'b0;
    redir_valid = 1'b1;
    redir_target = 32'h300;
    tick();
    redir_valid = 1'b0;
    #1;
    checks++;
    if (redir_pending !== 1'b1) begin fails++; $display("FAIL midpend_enter actual=%b expected=%b", redir_pending, 1'b1); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || redir_pending !== 1'b0) begin fails++; $display("FAIL midpend_async pc=%h pending=%b expected pc=0 pending=0", pc, redir_pending); end
    checks++;
    if (pc_next !== 32'h4) begin fails++; $display("FAIL midpend_pc_next actual=%h expected=%h", pc_next, 32'h4); end
    tick();
    rst_n = 1'b1;
    imem_ready = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h0) begin fails++; $display("FAIL midpend_release actual=%h expected=%h", pc, 32'h0); end
    tick();
    #1;
    checks++;
    if (pc !== 32'h4) begin fails++; $display("FAIL midpend_advance actual=%h expected=%h", pc, 32'h4); end
  endtask

  task automatic test_wrap();
    redir_valid = 1'b1;
    redir_target = 32'hFFFF_FFFC;
    tick();
    redir_valid = 1'b0;
    #1;
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top actual=%h expected=%h", pc, 32'hFFFF_FFFC); end
    tick();
    #1;
    checks++;
    if (pc !== 32'h0) begin fails++; $display("FAIL wrap_zero actual=%h expected=%h", pc, 32'h0); end
  endtask

  task automatic test_misalign();
    redir_valid = 1'b1;
    redir_target = 32'h102;
    #1;
`ifdef PC_MISALIGN_TRAP_EN
    checks++;
    if (misaligned !== 1'b1 || pc_next !== 32'h10) begin fails++; $display("FAIL trap_pulse misaligned=%b pc_next=%h expected 1 %h", misaligned, pc_next, 32'h10); end
    tick();
    redir_valid = 1'b0;
    #1;
    checks++;
    if (misaligned !== 1'b0 || pc !== 32'h10) begin fails++; $display("FAIL trap_pc misaligned=%b pc=%h expected 0 %h", misaligned, pc, 32'h10); end
    imem_ready = 1'b0;
    redir_valid = 1'b1;
    redir_target = 32'h203;
    tick();
    redir_valid = 1'b0;
    #1;
    checks++;
    if (pc_next !== 32'h10 || redir_pending !== 1'b1) begin fails++; $display("FAIL trap_pend pc_next=%h pending=%b expected %h 1", pc_next, redir_pending, 32'h10); end
    imem_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (pc !== 32'h10) begin fails++; $display("FAIL trap_pend_release actual=%h expected=%h", pc, 32'h10); end
`else
    checks++;
    if (pc_next !== 32'h100) begin fails++; $display("FAIL align_pc_next actual=%h expected=%h", pc_next, 32'h100); end
    tick();
    redir_valid = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h100) begin fails++; $display("FAIL align_pc actual=%h expected=%h", pc, 32'h100); end
`endif
  endtask

  initial begin
    checks = 0;
    fails = 0;
    test_reset();
    test_sequential();
    test_redirect();
    test_pend();
    test_stall();
    test_stall_redirect();
    test_pend_overwrite();
    test_pend_redirect_ready();
    test_reset_mid_pend();
    test_wrap();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
